seg7_scan_capture: RTL and testbench

Receive-side monitor for the multiplexed 7-segment display bus: active-low segments plus one active-low anode per digit, 8 digits. It samples the bus, waits for each (segment, anode) pair to settle, maps the segment pattern back to a hex nibble, and stores it per digit. When all 8 digits have been seen it publishes a reconstructed 32-bit value. It sits beside the display driver for self-check and board loopback, and is the reading end of the segment/anode interface.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_pattern_dec.sv | 38 +++
 rtl/seg7_scan_capture.sv | 169 ++++++++++++++++
 tb/tb_seg7_scan_capture.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Segment codes shared by the 7-segment display driver and the scan capture monitor.
// Patterns are active-low, bit0 = a ... bit6 = g.
package seg7_pkg;

    localparam int N_DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_pattern_dec.sv
// Maps an active-low segment pattern back to its hex nibble; anything outside
// the 16 legal codes (including the blank pattern) is flagged as illegal.
module seg7_pattern_dec (
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       legal
);
    import seg7_pkg::*;

    // Reverse lookup of the shared code table
    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        case (seg)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: begin
                nibble = 4'h0;
                legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive-side monitor of the multiplexed 7-segment bus: synchronises, waits for
// each (anode, segment) pair to settle, and rebuilds the 32-bit displayed value.
module seg7_scan_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [6:0]  I_seg,
    input  logic [7:0]  I_an,
    output logic [31:0] O_value,
    output logic        O_frame,
    output logic [7:0]  O_bad,
    output logic        O_overlap,
    output logic        O_timeout
);
    import seg7_pkg::*;

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_SETTLE = 2'd1;
    localparam logic [1:0]  ST_HELD   = 2'd2;
    localparam logic [7:0]  STABLE_W  = 8'(STABLE_CYCLES);
    localparam logic [24:0] TOUT_MAX  = 25'(TIMEOUT_CYCLES);

    logic [6:0]  seg_m_r, seg_s_r;
    logic [7:0]  an_m_r, an_s_r;
    logic [14:0] w_prev_r;
    logic [1:0]  state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [31:0] shadow_r, shadow_s;
    logic [7:0]  seen_r, seen_s;
    logic [24:0] tout_r, tout_s;
    logic [31:0] value_r;
    logic [7:0]  bad_r, bad_s;
    logic        frame_r, overlap_r, overlap_s, timeout_r;
    logic        changed_s, accept_s, frame_s;
    logic [7:0]  an_low_s;
    logic        blank_s, onehot_s;
    logic [2:0]  idx_s;
    logic [3:0]  nibble_s;
    logic        legal_s;

    seg7_pattern_dec u_dec (
        .seg    (seg_s_r),
        .nibble (nibble_s),
        .legal  (legal_s)
    );

    assign changed_s = ({an_s_r, seg_s_r} != w_prev_r);
    assign an_low_s  = ~an_s_r;
    assign blank_s   = (an_low_s == 8'h00);
    assign onehot_s  = !blank_s && ((an_low_s & (an_low_s - 8'd1)) == 8'h00);

    // Index of the selected digit; only meaningful when exactly one anode is low
    always_comb begin
        idx_s = 3'd0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (an_low_s[k]) begin
                idx_s = 3'(k);
            end else begin
                idx_s = idx_s;
            end
        end
    end

    // Settle FSM: a word must stay unchanged STABLE_CYCLES samples before one accept
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_HELD: begin
                if (changed_s) begin
                    state_s = ST_SETTLE;
                    cnt_s   = 8'd1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SETTLE: begin
                if (changed_s) begin
                    cnt_s = 8'd1;
                end else if ((cnt_r + 8'd1) == STABLE_W) begin
                    cnt_s    = cnt_r + 8'd1;
                    accept_s = 1'b1;
                    state_s  = ST_HELD;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // Accept action: capture a legal digit, or raise the sticky error flags
    always_comb begin
        shadow_s  = shadow_r;
        seen_s    = seen_r;
        bad_s     = bad_r;
        overlap_s = overlap_r;
        if (accept_s && onehot_s) begin
            if (legal_s) begin
                shadow_s[4*idx_s +: 4] = nibble_s;
                seen_s[idx_s]          = 1'b1;
            end else begin
                bad_s[idx_s] = 1'b1;
            end
        end else if (accept_s && !blank_s) begin
            overlap_s = 1'b1;
        end else begin
            overlap_s = overlap_r;
        end
        frame_s = accept_s && (seen_s == 8'hFF);
        if (frame_s) begin
            tout_s = 25'd0;
        end else if (tout_r == TOUT_MAX) begin
            tout_s = tout_r;
        end else begin
            tout_s = tout_r + 25'd1;
        end
    end

    // Synchroniser, FSM state and frame assembly registers
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            seg_m_r   <= SEG_BLANK;
            seg_s_r   <= SEG_BLANK;
            an_m_r    <= 8'hFF;
            an_s_r    <= 8'hFF;
            w_prev_r  <= {8'hFF, SEG_BLANK};
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            shadow_r  <= 32'h0;
            seen_r    <= 8'h00;
            tout_r    <= 25'd0;
            value_r   <= 32'h0;
            frame_r   <= 1'b0;
            bad_r     <= 8'h00;
            overlap_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            seg_m_r   <= I_seg;
            seg_s_r   <= seg_m_r;
            an_m_r    <= I_an;
            an_s_r    <= an_m_r;
            w_prev_r  <= {an_s_r, seg_s_r};
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            shadow_r  <= shadow_s;
            seen_r    <= frame_s ? 8'h00 : seen_s;
            tout_r    <= tout_s;
            value_r   <= frame_s ? shadow_s : value_r;
            frame_r   <= frame_s;
            bad_r     <= bad_s;
            overlap_r <= overlap_s;
            timeout_r <= (tout_s == TOUT_MAX);
        end
    end

    assign O_value   = value_r;
    assign O_frame   = frame_r;
    assign O_bad     = bad_r;
    assign O_overlap = overlap_r;
    assign O_timeout = timeout_r;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: one default instance plus one with a
// short timeout, both driven from the same bus.
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic [31:0] value, t_value;
    logic        frame, t_frame, ovl, t_ovl, tmo, t_tmo;
    logic [7:0]  bad, t_bad;
    int          errors = 0;
    int          checks = 0;
    int          frames = 0;
    int          t_frames = 0;
    int          f0;
    logic [6:0]  seg_tab [16];

    always #5 clk = ~clk;

    seg7_scan_capture dut (
        .I_clk(clk), .I_rst(rst), .I_seg(seg), .I_an(an),
        .O_value(value), .O_frame(frame), .O_bad(bad),
        .O_overlap(ovl), .O_timeout(tmo)
    );

    seg7_scan_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(32)) dut_t (
        .I_clk(clk), .I_rst(rst), .I_seg(seg), .I_an(an),
        .O_value(t_value), .O_frame(t_frame), .O_bad(t_bad),
        .O_overlap(t_ovl), .O_timeout(t_tmo)
    );

    always @(posedge clk) begin
        #1;
        if (frame === 1'b1) frames++;
        if (t_frame === 1'b1) t_frames++;
    end

    task drive(input logic [7:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task scan(input logic [31:0] v, input int first, input int last, input int n);
        logic [7:0] a;
        for (int d = first; d <= last; d++) begin
            a = ~(8'd1 << d);
            drive(a, seg_tab[v[4*d +: 4]], n);
        end
    endtask

    task do_reset;
        rst = 1'b1;
        an  = 8'hFF;
        seg = 7'h7F;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (value !== 32'h0 || frame !== 1'b0) begin errors++; $display("FAIL reset_value: got %h/%b expected 0/0", value, frame); end
        checks++; if (bad !== 8'h00 || ovl !== 1'b0 || tmo !== 1'b0) begin errors++; $display("FAIL reset_flags: got %h/%b/%b expected 0", bad, ovl, tmo); end
        rst = 1'b0;
        f0 = frames;
        repeat (100) @(negedge clk);
        checks++; if (frames !== f0) begin errors++; $display("FAIL idle_frames: got %0d expected %0d", frames, f0); end
        checks++; if (value !== 32'h0 || bad !== 8'h00 || ovl !== 1'b0 || tmo !== 1'b0) begin errors++; $display("FAIL idle_outputs: got %h/%h/%b/%b expected all 0", value, bad, ovl, tmo); end
    endtask

    task test_scan;
        do_reset();
        f0 = frames;
        scan(32'h87654321, 0, 6, 10);
        an  = 8'h7F;
        seg = seg_tab[8];
        repeat (5) @(negedge clk);
        checks++; if (frame !== 1'b0 || value !== 32'h0) begin errors++; $display("FAIL scan_early: got frame=%b value=%h expected 0/0", frame, value); end
        @(negedge clk);
        checks++; if (frame !== 1'b1) begin errors++; $display("FAIL scan_frame_timing: got %b expected 1", frame); end
        checks++; if (value !== 32'h87654321) begin errors++; $display("FAIL scan_value: got %h expected 87654321", value); end
        @(negedge clk);
        checks++; if (frame !== 1'b0) begin errors++; $display("FAIL scan_pulse_width: got %b expected 0", frame); end
        repeat (3) @(negedge clk);
        checks++; if (frames !== f0 + 1) begin errors++; $display("FAIL scan_frame_count: got %0d expected %0d", frames - f0, 1); end
    endtask

    task test_short;
        do_reset();
        f0 = frames;
        scan(32'hFEDCBA98, 0, 1, 10);
        drive(8'hFB, seg_tab[10], 3);
        scan(32'hFEDCBA98, 3, 7, 10);
        drive(8'hFF, 7'h7F, 10);
        checks++; if (frames !== f0) begin errors++; $display("FAIL short_no_frame: got %0d expected 0", frames - f0); end
        scan(32'h01234567, 0, 2, 4);
        drive(8'hFF, 7'h7F, 6);
        checks++; if (frames !== f0 + 1) begin errors++; $display("FAIL short_rescan_count: got %0d expected 1", frames - f0); end
        checks++; if (value !== 32'hFEDCB567) begin errors++; $display("FAIL short_rescan_value: got %h expected FEDCB567", value); end
    endtask

    task test_bad;
        do_reset();
        f0 = frames;
        drive(8'hFB, 7'b1010101, 10);
        checks++; if (bad !== 8'h04) begin errors++; $display("FAIL bad_flag: got %h expected 04", bad); end
        scan(32'h76543210, 0, 1, 10);
        scan(32'h76543210, 3, 7, 10);
        checks++; if (frames !== f0) begin errors++; $display("FAIL bad_no_frame: got %0d expected 0", frames - f0); end
        scan(32'h76543210, 2, 2, 10);
        checks++; if (frames !== f0 + 1 || value !== 32'h76543210) begin errors++; $display("FAIL bad_resend: got %0d/%h expected 1/76543210", frames - f0, value); end
        checks++; if (bad !== 8'h04) begin errors++; $display("FAIL bad_sticky: got %h expected 04", bad); end
    endtask

    task test_overlap;
        f0 = frames;
        drive(8'hFC, seg_tab[1], 10);
        checks++; if (ovl !== 1'b1 || frames !== f0 || bad !== 8'h04) begin errors++; $display("FAIL overlap_flag: got %b/%0d/%h expected 1/0/04", ovl, frames - f0, bad); end
        scan(32'h13579BDF, 0, 7, 10);
        checks++; if (frames !== f0 + 1 || value !== 32'h13579BDF) begin errors++; $display("FAIL overlap_frame: got %0d/%h expected 1/13579BDF", frames - f0, value); end
        checks++; if (ovl !== 1'b1) begin errors++; $display("FAIL overlap_sticky: got %b expected 1", ovl); end
    endtask

    task test_reset_mid;
        scan(32'h2468ACE0, 0, 4, 10);
        rst = 1'b1;
        #1;
        checks++; if (value !== 32'h0 || frame !== 1'b0 || bad !== 8'h00 || ovl !== 1'b0) begin errors++; $display("FAIL midreset_async: got %h/%b/%h/%b expected all 0", value, frame, bad, ovl); end
        @(negedge clk);
        rst = 1'b0;
        f0 = frames;
        scan(32'h0F1E2D3C, 5, 7, 10);
        checks++; if (frames !== f0) begin errors++; $display("FAIL midreset_discard: got %0d expected 0", frames - f0); end
        scan(32'h0F1E2D3C, 0, 7, 10);
        checks++; if (frames !== f0 + 1 || value !== 32'h0F1E2D3C) begin errors++; $display("FAIL midreset_value: got %0d/%h expected 1/0F1E2D3C", frames - f0, value); end
    endtask

    task test_timeout;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 31) begin
                checks++; if (t_tmo !== 1'b0) begin errors++; $display("FAIL timeout_before: got %b expected 0", t_tmo); end
            end else if (k == 32) begin
                checks++; if (t_tmo !== 1'b1) begin errors++; $display("FAIL timeout_rise: got %b expected 1", t_tmo); end
            end else if (k == 40) begin
                checks++; if (t_tmo !== 1'b1 || tmo !== 1'b0) begin errors++; $display("FAIL timeout_hold: got %b/%b expected 1/0", t_tmo, tmo); end
            end
        end
        f0 = t_frames;
        scan(32'h11223344, 0, 6, 10);
        checks++; if (t_tmo !== 1'b1) begin errors++; $display("FAIL timeout_midscan: got %b expected 1", t_tmo); end
        scan(32'h11223344, 7, 7, 10);
        checks++; if (t_frames !== f0 + 1 || t_value !== 32'h11223344) begin errors++; $display("FAIL timeout_frame: got %0d/%h expected 1/11223344", t_frames - f0, t_value); end
        checks++; if (t_tmo !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b expected 0", t_tmo); end
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
        rst = 1'b1;
        an  = 8'hFF;
        seg = 7'h7F;
        @(negedge clk);
        test_reset();
        test_scan();
        test_short();
        test_bad();
        test_overlap();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
